// File: rtl/btb_dm_ctrl.sv
// -----------------------------------------------------------------------------
// btb_dm_ctrl : direct-mapped branch target buffer beside the fetch stage.
//
// The fetch PC is looked up combinationally in the same cycle, and the block
// returns a predicted direction and target. When a branch resolves in EX, the
// block flags a misprediction by comparing the resolved outcome with the
// prediction that travelled down the pipe. On the same cycle it trains the
// table.
//
// Configuration macro: BTB_BHT_EN
//   defined   : each entry carries a 2-bit saturating direction counter, and
//               the counter MSB decides the predicted direction.
//   undefined : no counters. Any hit predicts taken, and a not-taken resolve
//               that hits drops the entry.
//
// Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. PC 0 never hits and is
// never allocated.
// -----------------------------------------------------------------------------
module btb_dm_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ENTRY_NUM = 16,
    parameter int unsigned IDX_W     = 4,
    parameter logic [1:0]  CNT_INIT  = 2'b10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    input  logic              inv_all_i,
    output logic              mispredict_o
);

    localparam int unsigned       TAG_W         = ADDR_W - IDX_W - 2;
    localparam logic              JMP_EN        = 1'b1;
    localparam logic              JMP_DIS       = 1'b0;
    localparam logic              JMP_ERROR     = 1'b1;
    localparam logic [ADDR_W-1:0] MEM_ADDR_ZERO = '0;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [ENTRY_NUM-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag    [ENTRY_NUM];
    logic [ADDR_W-1:0]    r_target [ENTRY_NUM];
`ifdef BTB_BHT_EN
    logic [1:0]           r_cnt    [ENTRY_NUM];
`else
    // Counter initial value is meaningless without counters.
    logic                 w_unused_cnt_init;
    assign w_unused_cnt_init = ^CNT_INIT;
`endif

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_l_idx;
    logic [TAG_W-1:0] w_l_tag;
    logic             w_l_hit;
    logic             w_l_dir;

    assign w_l_idx = pc_i[IDX_W+1:2];
    assign w_l_tag = pc_i[ADDR_W-1:IDX_W+2];
    assign w_l_hit = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag) && (pc_i != '0);

`ifdef BTB_BHT_EN
    assign w_l_dir = w_l_hit && r_cnt[w_l_idx][1];
`else
    assign w_l_dir = w_l_hit;
`endif

    // Predictions are forced quiet while reset is held so the fetch stage never
    // follows stale table contents.
    always_comb begin
        pred_taken_o  = JMP_DIS;
        pred_target_o = MEM_ADDR_ZERO;
        if (rst_n && w_l_dir) begin
            pred_taken_o  = JMP_EN;
            pred_target_o = r_target[w_l_idx];
        end
    end

    // ------------------------------------------------------------------
    // Resolve-side lookup and misprediction detection
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_pc_nz;
    logic             w_u_hit;
    logic             w_misp;

    assign w_u_idx   = upd_pc_i[IDX_W+1:2];
    assign w_u_tag   = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign w_u_pc_nz = (upd_pc_i != '0);
    assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag) && w_u_pc_nz;

    // A taken branch that went to the wrong target is as costly as a wrong
    // direction. For a not-taken branch, only the direction matters.
    assign w_misp = upd_valid_i &&
                    ((upd_taken_i != upd_pred_taken_i) ||
                     (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    // Misprediction flag, held quiet during reset.
    always_comb begin
        mispredict_o = ~JMP_ERROR;
        if (rst_n && w_misp) begin
            mispredict_o = JMP_ERROR;
        end
    end

`ifdef BTB_BHT_EN
    // ------------------------------------------------------------------
    // Saturating counter arithmetic for the entry being trained
    // ------------------------------------------------------------------
    logic [1:0] w_cnt_cur;
    logic [1:0] w_cnt_inc;
    logic [1:0] w_cnt_dec;

    assign w_cnt_cur = r_cnt[w_u_idx];

    // Next counter values, clamped at both ends.
    always_comb begin
        w_cnt_inc = w_cnt_cur;
        w_cnt_dec = w_cnt_cur;
        if (w_cnt_cur != 2'b11) begin
            w_cnt_inc = w_cnt_cur + 2'b01;
        end
        if (w_cnt_cur != 2'b00) begin
            w_cnt_dec = w_cnt_cur - 2'b01;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    // Reset clears the table. A full invalidate wins over a resolve in the same
    // cycle. Otherwise the resolve trains or allocates the indexed entry. The
    // lookup above reads the old contents, so a same-index write becomes
    // visible on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(ENTRY_NUM); i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
`ifdef BTB_BHT_EN
                r_cnt[i]    <= 2'b01;
`endif
            end
        end else if (inv_all_i) begin
            r_valid <= '0;
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                if (w_u_hit) begin
                    r_target[w_u_idx] <= upd_target_i;
`ifdef BTB_BHT_EN
                    r_cnt[w_u_idx]    <= w_cnt_inc;
`endif
                end else if (w_u_pc_nz) begin
                    // A taken miss replaces whatever was aliased on this index.
                    r_valid[w_u_idx]  <= 1'b1;
                    r_tag[w_u_idx]    <= w_u_tag;
                    r_target[w_u_idx] <= upd_target_i;
`ifdef BTB_BHT_EN
                    r_cnt[w_u_idx]    <= CNT_INIT;
`endif
                end
            end else if (w_u_hit) begin
`ifdef BTB_BHT_EN
                r_cnt[w_u_idx]   <= w_cnt_dec;
`else
                r_valid[w_u_idx] <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_btb_dm_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for btb_dm_ctrl (default parameters: 16 entries, 32-bit PCs).
// The driver applies one cycle of stimulus at each falling edge. It pushes the
// response expected from a reference table model, then advances the model to
// its post-edge state. A separate monitor samples the DUT shortly after each
// falling edge and compares the sample with the queued expectation. Follows
// BTB_BHT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_btb_dm_ctrl;

    localparam int N = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic [31:0] upd_pred_target_i;
    logic        inv_all_i;
    logic        mispredict_o;

    btb_dm_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_i              (pc_i),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .inv_all_i         (inv_all_i),
        .mispredict_o      (mispredict_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per index.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];

    typedef struct {
        int          step;
        logic        taken;
        logic [31:0] target;
        logic        misp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> 6);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return (pc != 0) && m_valid[i] && (m_tag[i] == tag_of(pc));
    endfunction

    function automatic bit m_dir(input logic [31:0] pc);
`ifdef BTB_BHT_EN
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
`else
        return m_hit(pc);
`endif
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_dir(pc) ? m_tgt[idx_of(pc)] : 32'h0;
    endfunction

    task automatic step(input bit rst_b, input logic [31:0] pc,
                        input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utgt, input bit upt,
                        input logic [31:0] uptgt, input bit inv);
        exp_t e;
        int   i;
        @(negedge clk);
        rst_n = rst_b; pc_i = pc; upd_valid_i = uv; upd_pc_i = upc;
        upd_taken_i = ut; upd_target_i = utgt; upd_pred_taken_i = upt;
        upd_pred_target_i = uptgt; inv_all_i = inv;
        e.step = step_no;
        step_no++;
        if (!rst_b) begin
            e.taken = 1'b0; e.target = 32'h0; e.misp = 1'b0;
        end else begin
            e.taken  = m_dir(pc);
            e.target = m_target(pc);
            e.misp   = uv && ((ut != upt) || (ut && (utgt != uptgt)));
        end
        q.push_back(e);
        // Advance the model to the state after the coming rising edge.
        i = idx_of(upc);
        if (!rst_b) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_cnt[k] = 1; m_tgt[k] = 32'h0; m_tag[k] = 0;
            end
        end else if (inv) begin
            for (int k = 0; k < N; k++) m_valid[k] = 0;
        end else if (uv) begin
            if (ut) begin
                if (m_hit(upc)) begin
                    m_tgt[i] = utgt;
                    m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                end else if (upc != 0) begin
                    m_valid[i] = 1; m_tag[i] = tag_of(upc);
                    m_tgt[i] = utgt; m_cnt[i] = 2;
                end
            end else if (m_hit(upc)) begin
`ifdef BTB_BHT_EN
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
`else
                m_valid[i] = 0;
`endif
            end
        end
    endtask

    task automatic look(input logic [31:0] pc);
        step(1, pc, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] upc, input bit ut,
                           input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
        step(1, pc, 1, upc, ut, utgt, upt, uptgt, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] t;
        logic [31:0] ix;
        if ($urandom_range(0, 19) == 0) return 32'h0;
        t  = 32'($urandom_range(4, 5));
        ix = 32'($urandom_range(0, 3));
        return (t << 6) | (ix << 2);
    endfunction

    // Monitor: this block produces a response every cycle, so the monitor
    // pops one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (pred_taken_o !== e.taken) begin
                    n_fail++;
                    $display("FAIL pred_taken step %0d: got %0b expected %0b", e.step, pred_taken_o, e.taken);
                end
                n_tests++;
                if (pred_target_o !== e.target) begin
                    n_fail++;
                    $display("FAIL pred_target step %0d: got %08h expected %08h", e.step, pred_target_o, e.target);
                end
                n_tests++;
                if (mispredict_o !== e.misp) begin
                    n_fail++;
                    $display("FAIL mispredict step %0d: got %0b expected %0b", e.step, mispredict_o, e.misp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, upc, tgt, ptgt;
        bit          ut, pt, inv, rb;

        rst_n = 1'b0; pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0;
        upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0;
        upd_pred_target_i = '0; inv_all_i = 1'b0;

        // Reset, and check outputs while held.
        step(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0, 0);
        step(0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        // Allocation on first taken resolve; lookup in the same cycle still misses.
        resolve(32'h100, 32'h100, 1, 32'h200, 0, 32'h0);
        look(32'h100);
        look(32'h0);

        // Counter saturation up, then down to zero, then one step back.
        repeat (3) resolve(32'h100, 32'h100, 1, 32'h200, m_dir(32'h100), m_target(32'h100));
        look(32'h100);
        repeat (2) resolve(32'h100, 32'h100, 0, 32'h0, m_dir(32'h100), m_target(32'h100));
        look(32'h100);
        repeat (2) resolve(32'h100, 32'h100, 0, 32'h0, m_dir(32'h100), m_target(32'h100));
        resolve(32'h100, 32'h100, 1, 32'h200, 0, 32'h0);
        look(32'h100);

        // Target change on a predicted-taken branch.
        step(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        resolve(32'h0, 32'h100, 1, 32'h200, 0, 32'h0);
        resolve(32'h100, 32'h100, 1, 32'h300, 1, 32'h200);
        look(32'h100);
        // Not-taken branch whose predicted target differs is not a mispredict.
        resolve(32'h100, 32'h200, 0, 32'h1234, 0, 32'h500);

        // Aliasing on index 0.
        resolve(32'h140, 32'h140, 1, 32'h400, 0, 32'h0);
        look(32'h100);
        look(32'h140);
        resolve(32'h140, 32'h180, 0, 32'h0, 0, 32'h0);
        look(32'h140);
        look(32'h180);

        // Invalidate-all overriding a simultaneous allocation.
        resolve(32'h100, 32'h100, 1, 32'h600, 0, 32'h0);
        step(1, 32'h100, 1, 32'h1c0, 1, 32'h700, 0, 32'h0, 1);
        look(32'h100);
        look(32'h1c0);
        look(32'h140);

        // PC 0 is never allocated.
        resolve(32'h0, 32'h0, 1, 32'h800, 0, 32'h0);
        look(32'h0);

        // A reset pulse discards a pending resolve.
        step(0, 32'h100, 1, 32'h100, 1, 32'h900, 0, 32'h0, 0);
        look(32'h100);

        // Randomized traffic with mostly coherent pipeline predictions.
        for (int n = 0; n < 600; n++) begin
            pc   = rand_pc();
            upc  = rand_pc();
            ut   = 1'($urandom_range(0, 1));
            tgt  = $urandom & 32'hffff_fffc;
            if ($urandom_range(0, 1) == 1 && m_tgt[idx_of(upc)] != 0)
                tgt = m_tgt[idx_of(upc)];
            if ($urandom_range(0, 9) < 7) begin
                pt   = m_dir(upc);
                ptgt = m_target(upc);
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = $urandom & 32'hffff_fffc;
            end
            inv = ($urandom_range(0, 49) == 0);
            rb  = ($urandom_range(0, 79) != 0);
            step(rb, pc, 1'($urandom_range(0, 3) != 0), upc, ut, tgt, pt, ptgt, inv);
        end

        @(negedge clk);
        #4;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
